// File: rtl/ro_freq_meter.sv
// rtl/ro_freq_meter.sv - ring oscillator frequency meter: gated rising-edge counter with start/done handshake
`timescale 1ns/1ps
module ro_freq_meter #(
    parameter int GATE_CYCLES   = 1000,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ro_clk_i,
    output logic             ro_en_o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow
);
    localparam int TW = $clog2(((GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES) + 1);
    localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]    GATE_LAST   = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_GATE, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [TW-1:0]    r_timer;
    logic             r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_ovf, w_ovf_next;
    logic             w_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= ro_clk_i;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;

    // Saturating count; a rise at full scale only raises the overflow flag.
    always_comb begin
        w_cnt_next = r_cnt;
        w_ovf_next = r_ovf;
        if (w_rise) begin
            if (r_cnt == CNT_MAX) w_ovf_next = 1'b1;
            else                  w_cnt_next = r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next  = r_state;
        ro_en_o = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                ro_en_o = 1'b1;
                if (r_timer == SETTLE_LAST) w_next = S_GATE;
            end
            S_GATE: begin
                ro_en_o = 1'b1;
                if (r_timer == GATE_LAST) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            if (r_state != w_next)
                r_timer <= '0;
            else if (r_state == S_SETTLE || r_state == S_GATE)
                r_timer <= r_timer + 1'b1;
        end
    end

    // The result is loaded on the edge into DONE so it is already valid while done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            count_o  <= '0;
            overflow <= 1'b0;
        end else begin
            if (r_state == S_SETTLE && w_next == S_GATE) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (r_state == S_GATE) begin
                r_cnt <= w_cnt_next;
                r_ovf <= w_ovf_next;
            end
            if (r_state == S_GATE && w_next == S_DONE) begin
                count_o  <= w_cnt_next;
                overflow <= w_ovf_next;
            end
        end
    end
endmodule

// File: tb/tb_ro_freq_meter.sv
// tb/tb_ro_freq_meter.sv - self-checking bench for ro_freq_meter
`timescale 1ns/1ps
module tb_ro_freq_meter;
    localparam int G = 1000;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ro_a = 1'b0, ro_b = 1'b0;
    logic        en_a, busy_a, done_a, ovf_a;
    logic        en_b, busy_b, done_b, ovf_b;
    logic [15:0] cnt_a;
    logic [5:0]  cnt_b;

    int checks = 0;
    int failures = 0;
    int half_a = 20;
    int half_b = 20;
    bit dead = 1'b0;

    ro_freq_meter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .ro_clk_i(ro_a), .ro_en_o(en_a),
        .busy(busy_a), .done(done_a), .count_o(cnt_a), .overflow(ovf_a));

    ro_freq_meter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(6)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .ro_clk_i(ro_b), .ro_en_o(en_b),
        .busy(busy_b), .done(done_b), .count_o(cnt_b), .overflow(ovf_b));

    always #5 clk = ~clk;

    // Oscillator models: run only while enabled, random phase kept off clk edges.
    always begin
        ro_a = 1'b0;
        wait (en_a && !dead);
        #(1.5 + $urandom_range(0, 7));
        while (en_a) begin
            ro_a = ~ro_a;
            #(half_a);
        end
    end

    always begin
        ro_b = 1'b0;
        wait (en_b && !dead);
        #(1.5 + $urandom_range(0, 7));
        while (en_b) begin
            ro_b = ~ro_b;
            #(half_b);
        end
    end

    // Reference: rises in a window of gate*10 ns with period 2*half, within one edge.
    function automatic bit near(input int c, input int half, input int gate);
        int p;
        p = 2 * half;
        return (c * p >= gate * 10 - p) && (c * p <= gate * 10 + p);
    endfunction

    task automatic measure(input bit hold, output int lat, output int en_cyc);
        @(negedge clk);
        start  = 1'b1;
        lat    = 0;
        en_cyc = 0;
        do begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            lat++;
            if (en_a) en_cyc++;
        end while (!done_a && lat < 3000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (en_a !== 1'b0) begin failures++; $display("FAIL rst_en got=%0b exp=0", en_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", done_a); end
        checks++; if (cnt_a !== 16'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", cnt_a); end
        checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%0b exp=0", ovf_a); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_nominal();
        int lat, en_cyc;
        half_a = 20;
        half_b = 20;
        measure(1'b0, lat, en_cyc);
        checks++; if (lat !== S + G + 1) begin failures++; $display("FAIL nom_latency got=%0d exp=%0d", lat, S + G + 1); end
        checks++; if (en_cyc !== S + G) begin failures++; $display("FAIL nom_en_cycles got=%0d exp=%0d", en_cyc, S + G); end
        checks++; if (near(int'(cnt_a), 20, G) !== 1'b1) begin failures++; $display("FAIL nom_count got=%0d exp=250+-1", cnt_a); end
        checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL nom_ovf got=%0b exp=0", ovf_a); end
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL nom_busy_after got=%0b exp=0", busy_a); end
        repeat (10) @(negedge clk);
        checks++; if (near(int'(cnt_a), 20, G) !== 1'b1) begin failures++; $display("FAIL nom_persist got=%0d exp=250+-1", cnt_a); end
    endtask

    task automatic test_saturation();
        int lat, en_cyc;
        half_a = 20;
        half_b = 20;
        measure(1'b0, lat, en_cyc);
        checks++; if (cnt_b !== 6'd63) begin failures++; $display("FAIL sat_count got=%0d exp=63", cnt_b); end
        checks++; if (ovf_b !== 1'b1) begin failures++; $display("FAIL sat_ovf got=%0b exp=1", ovf_b); end
        repeat (10) @(negedge clk);
        half_b = 200;
        measure(1'b0, lat, en_cyc);
        checks++; if (near(int'(cnt_b), 200, G) !== 1'b1) begin failures++; $display("FAIL sat2_count got=%0d exp=25+-1", cnt_b); end
        checks++; if (ovf_b !== 1'b0) begin failures++; $display("FAIL sat2_ovf got=%0b exp=0", ovf_b); end
        half_b = 20;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_start_busy();
        int ndone, dlat, busy_after;
        logic [15:0] c;
        ndone = 0; dlat = 0; busy_after = -1; c = '0;
        half_a = 20;
        @(negedge clk);
        start = 1'b1;
        for (int lat = 1; lat <= 1200; lat++) begin
            @(negedge clk);
            start = (lat == S + 500);
            if (done_a) begin
                ndone++;
                if (dlat == 0) begin dlat = lat; c = cnt_a; end
            end
            if (dlat != 0 && lat == dlat + 1) busy_after = int'(busy_a);
        end
        checks++; if (ndone !== 1) begin failures++; $display("FAIL busy_ndone got=%0d exp=1", ndone); end
        checks++; if (dlat !== S + G + 1) begin failures++; $display("FAIL busy_latency got=%0d exp=%0d", dlat, S + G + 1); end
        checks++; if (busy_after !== 0) begin failures++; $display("FAIL busy_drop got=%0d exp=0", busy_after); end
        checks++; if (near(int'(c), 20, G) !== 1'b1) begin failures++; $display("FAIL busy_count got=%0d exp=250+-1", c); end
    endtask

    task automatic test_reset_mid_gate();
        int ndone, lat, en_cyc;
        ndone = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= S + 300; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1 rst = 1'b1;
        #1;
        checks++; if (en_a !== 1'b0) begin failures++; $display("FAIL mid_rst_en got=%0b exp=0", en_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%0b exp=0", busy_a); end
        checks++; if (cnt_a !== 16'd0) begin failures++; $display("FAIL mid_rst_count got=%0d exp=0", cnt_a); end
        #2 rst = 1'b0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        checks++; if (ndone !== 0) begin failures++; $display("FAIL mid_rst_done got=%0d exp=0", ndone); end
        measure(1'b0, lat, en_cyc);
        checks++; if (lat !== S + G + 1) begin failures++; $display("FAIL mid_rst_latency got=%0d exp=%0d", lat, S + G + 1); end
        checks++; if (near(int'(cnt_a), half_a, G) !== 1'b1) begin failures++; $display("FAIL mid_rst_count2 got=%0d exp=250+-1", cnt_a); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_dead();
        int lat, en_cyc;
        dead = 1'b1;
        repeat (10) @(negedge clk);
        measure(1'b0, lat, en_cyc);
        checks++; if (lat !== S + G + 1) begin failures++; $display("FAIL dead_latency got=%0d exp=%0d", lat, S + G + 1); end
        checks++; if (cnt_a !== 16'd0) begin failures++; $display("FAIL dead_count got=%0d exp=0", cnt_a); end
        checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL dead_ovf got=%0b exp=0", ovf_a); end
        checks++; if (cnt_b !== 6'd0) begin failures++; $display("FAIL dead_sat_count got=%0d exp=0", cnt_b); end
        dead = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, en_cyc, gap, enlow;
        half_a = 20;
        measure(1'b1, lat, en_cyc);
        checks++; if (lat !== S + G + 1) begin failures++; $display("FAIL b2b_first got=%0d exp=%0d", lat, S + G + 1); end
        for (int r = 0; r < 2; r++) begin
            gap = 0;
            enlow = 0;
            do begin
                @(negedge clk);
                gap++;
                if (!en_a) enlow++;
            end while (!done_a && gap < 3000);
            checks++; if (gap !== S + G + 2) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", gap, S + G + 2); end
            checks++; if (enlow !== 2) begin failures++; $display("FAIL b2b_en_low got=%0d exp=2", enlow); end
            checks++; if (near(int'(cnt_a), 20, G) !== 1'b1) begin failures++; $display("FAIL b2b_count got=%0d exp=250+-1", cnt_a); end
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_random_periods();
        int lat, en_cyc;
        for (int i = 0; i < 3; i++) begin
            half_a = 20 + int'($urandom_range(0, 30));
            half_b = 100 + int'($urandom_range(0, 50));
            repeat (10) @(negedge clk);
            measure(1'b0, lat, en_cyc);
            checks++; if (near(int'(cnt_a), half_a, G) !== 1'b1) begin failures++; $display("FAIL rnd_count half=%0d got=%0d exp~%0d", half_a, cnt_a, G * 10 / (2 * half_a)); end
            checks++; if (near(int'(cnt_b), half_b, G) !== 1'b1) begin failures++; $display("FAIL rnd_sat_count half=%0d got=%0d exp~%0d", half_b, cnt_b, G * 10 / (2 * half_b)); end
            checks++; if (ovf_b !== 1'b0) begin failures++; $display("FAIL rnd_sat_ovf got=%0b exp=0", ovf_b); end
        end
        half_a = 20;
        half_b = 20;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_saturation();
        test_start_busy();
        test_reset_mid_gate();
        test_dead();
        test_back_to_back();
        test_random_periods();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
